// File: rtl/maze_carver.sv
// maze_carver: carves a perfect maze into a 16x16 tile bitmap using a
// randomized depth-first search driven by a 16-bit Fibonacci LFSR.
module maze_carver #(
   parameter int          CELLS     = 64,
   parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [15:0]  seed,
   input  logic [4:0]   maze_width,
   input  logic [4:0]   maze_height,
   output logic [255:0] path_data,
   output logic [4:0]   start_x,
   output logic [4:0]   start_y,
   output logic [4:0]   finish_x,
   output logic [4:0]   finish_y,
   output logic         busy,
   output logic         done
);
   typedef enum logic [2:0] {IDLE, CLEAR, INIT, PICK, CARVE, BACKTRACK} state_t;
   state_t      state;
   logic [3:0]  ew, eh, cx, cy, tx, ty, wx, wy;
   logic [15:0] lfsr;
   logic [6:0]  sp;
   logic [1:0]  dir, pick, first;
   logic [3:0]  mask, rot;
   logic [5:0]  stack [CELLS];
   logic [5:0]  top;

   function automatic logic [3:0] eff(input logic [4:0] d);
      return (d > 5'd15) ? 4'd15 : (d < 5'd3) ? 4'd3 : (d[3:0] | 4'd1);
   endfunction

   // Neighbour two tiles away must be a cell in range and still uncarved.
   always_comb begin
      mask[0] = (cy >= 4'd3) && !path_data[{cy - 4'd2, cx}];
      mask[1] = (cx + 4'd2 <= ew - 4'd2) && !path_data[{cy, cx + 4'd2}];
      mask[2] = (cy + 4'd2 <= eh - 4'd2) && !path_data[{cy + 4'd2, cx}];
      mask[3] = (cx >= 4'd3) && !path_data[{cy, cx - 4'd2}];
      rot     = 4'({mask, mask} >> lfsr[1:0]);
      first   = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
      pick    = lfsr[1:0] + first;
      tx      = (dir == 2'd1) ? cx + 4'd2 : (dir == 2'd3) ? cx - 4'd2 : cx;
      ty      = (dir == 2'd0) ? cy - 4'd2 : (dir == 2'd2) ? cy + 4'd2 : cy;
      wx      = (dir == 2'd1) ? cx + 4'd1 : (dir == 2'd3) ? cx - 4'd1 : cx;
      wy      = (dir == 2'd0) ? cy - 4'd1 : (dir == 2'd2) ? cy + 4'd1 : cy;
      top     = stack[6'(sp - 7'd2)];
   end

   always_ff @(posedge clk) begin
      if (state == INIT)
         stack[0] <= 6'd0;
      else if (state == CARVE)
         stack[6'(sp)] <= {ty[3:1], tx[3:1]};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         ew        <= 4'd3;
         eh        <= 4'd3;
         cx        <= 4'd1;
         cy        <= 4'd1;
         dir       <= 2'd0;
         lfsr      <= LFSR_INIT;
         sp        <= 7'd0;
         path_data <= '0;
         start_x   <= 5'd0;
         start_y   <= 5'd0;
         finish_x  <= 5'd0;
         finish_y  <= 5'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         if (busy)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         case (state)
            IDLE: if (start) begin
               ew    <= eff(maze_width);
               eh    <= eff(maze_height);
               lfsr  <= (seed == 16'd0) ? LFSR_INIT : seed;
               done  <= 1'b0;
               busy  <= 1'b1;
               state <= CLEAR;
            end
            CLEAR: begin
               path_data <= '0;
               done      <= 1'b0;
               state     <= INIT;
            end
            INIT: begin
               path_data[17] <= 1'b1;
               cx            <= 4'd1;
               cy            <= 4'd1;
               sp            <= 7'd1;
               state         <= PICK;
            end
            PICK: begin
               dir   <= pick;
               state <= (mask != 4'd0) ? CARVE : BACKTRACK;
            end
            CARVE: begin
               path_data[{wy, wx}] <= 1'b1;
               path_data[{ty, tx}] <= 1'b1;
               cx                  <= tx;
               cy                  <= ty;
               sp                  <= sp + 7'd1;
               state               <= PICK;
            end
            BACKTRACK: begin
               sp <= sp - 7'd1;
               if (sp == 7'd1) begin
                  start_x  <= 5'd1;
                  start_y  <= 5'd1;
                  finish_x <= {1'b0, ew - 4'd2};
                  finish_y <= {1'b0, eh - 4'd2};
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= IDLE;
               end else begin
                  cx    <= {top[2:0], 1'b1};
                  cy    <= {top[5:3], 1'b1};
                  state <= PICK;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_maze_carver.sv
// tb_maze_carver: checks maze_carver against a DFS reference model every cycle,
// plus directed checks of latency, maze shape and tree structure.
module tb_maze_carver;
   logic         clk = 1'b0, reset = 1'b0, start = 1'b0;
   logic [15:0]  seed = 16'd0;
   logic [4:0]   mw = 5'd3, mh = 5'd3;
   logic [255:0] path_data;
   logic [4:0]   start_x, start_y, finish_x, finish_y;
   logic         busy, done;
   int           tests = 0, fails = 0;

   maze_carver dut (
      .clk(clk), .reset(reset), .start(start), .seed(seed),
      .maze_width(mw), .maze_height(mh), .path_data(path_data),
      .start_x(start_x), .start_y(start_y), .finish_x(finish_x), .finish_y(finish_y),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [255:0] p;
      logic [31:0]  cyc;
      logic [4:0]   fx;
      logic [4:0]   fy;
   } res_t;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int eff(input int d);
      return (d > 15) ? 15 : (d < 3) ? 3 : (d | 1);
   endfunction

   function automatic logic [15:0] adv(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   // Reference DFS; every step (clear, init, pick, carve, pop) costs one clock and one LFSR shift.
   function automatic res_t model(input int w, input int h, input logic [15:0] s);
      res_t        r;
      int          ew, eh, x, y, rr, d, k, nx, ny;
      int          sx[$], sy[$];
      int          dx[4], dy[4];
      logic [15:0] l;
      dx = '{0, 1, 0, -1};
      dy = '{-1, 0, 1, 0};
      ew = eff(w);
      eh = eff(h);
      l = (s == 16'd0) ? 16'hACE1 : s;
      r.p = '0;
      l = adv(adv(l));
      r.cyc = 2;
      x = 1;
      y = 1;
      r.p[17] = 1'b1;
      sx.push_back(1);
      sy.push_back(1);
      while (sx.size() > 0) begin
         rr = int'(l[1:0]);
         d = -1;
         l = adv(l);
         r.cyc++;
         for (int i = 0; i < 4; i++) begin
            k = (rr + i) % 4;
            nx = x + 2 * dx[k];
            ny = y + 2 * dy[k];
            if (d < 0 && nx >= 1 && nx <= ew - 2 && ny >= 1 && ny <= eh - 2 && !r.p[nx + 16 * ny])
               d = k;
         end
         l = adv(l);
         r.cyc++;
         if (d >= 0) begin
            r.p[(x + dx[d]) + 16 * (y + dy[d])] = 1'b1;
            x = x + 2 * dx[d];
            y = y + 2 * dy[d];
            r.p[x + 16 * y] = 1'b1;
            sx.push_back(x);
            sy.push_back(y);
         end else begin
            void'(sx.pop_back());
            void'(sy.pop_back());
            if (sx.size() > 0) begin
               x = sx[$];
               y = sy[$];
            end
         end
      end
      r.fx = 5'(ew - 2);
      r.fy = 5'(eh - 2);
      return r;
   endfunction

   // Independent structural check: returns number of violations of the spanning-tree shape.
   function automatic int tree_errs(input logic [255:0] p, input int ew, input int eh);
      int   errs, n, cnt, c, x, y, wx, wy, tx, ty;
      int   q[$];
      int   dx[4], dy[4];
      logic [255:0] seen;
      dx = '{0, 1, 0, -1};
      dy = '{-1, 0, 1, 0};
      errs = 0;
      n = 0;
      for (int yy = 0; yy < 16; yy++)
         for (int xx = 0; xx < 16; xx++) begin
            if (xx >= ew - 1 || yy >= eh - 1 || xx == 0 || yy == 0) begin
               if (p[xx + 16 * yy]) errs++;
            end else if (xx % 2 == 1 && yy % 2 == 1) begin
               n++;
               if (!p[xx + 16 * yy]) errs++;
            end else if (xx % 2 == 0 && yy % 2 == 0) begin
               if (p[xx + 16 * yy]) errs++;
            end
         end
      if ($countones(p) != 2 * n - 1) errs++;
      seen = '0;
      seen[17] = 1'b1;
      q.push_back(17);
      cnt = 0;
      while (q.size() > 0) begin
         c = q.pop_front();
         cnt++;
         x = c % 16;
         y = c / 16;
         for (int k = 0; k < 4; k++) begin
            wx = x + dx[k];
            wy = y + dy[k];
            tx = x + 2 * dx[k];
            ty = y + 2 * dy[k];
            if (tx >= 0 && tx < 16 && ty >= 0 && ty < 16 && p[wx + 16 * wy] && !seen[tx + 16 * ty]) begin
               seen[tx + 16 * ty] = 1'b1;
               q.push_back(tx + 16 * ty);
            end
         end
      end
      if (cnt != n) errs++;
      return errs;
   endfunction

   logic       m_busy = 1'b0, m_done = 1'b0;
   int         m_left = 0;
   res_t       m_res;
   logic [255:0] m_path = '0;
   logic [4:0] m_sx = 5'd0, m_sy = 5'd0, m_fx = 5'd0, m_fy = 5'd0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_left <= 0;
         m_path <= '0;
         m_sx   <= 5'd0;
         m_sy   <= 5'd0;
         m_fx   <= 5'd0;
         m_fy   <= 5'd0;
      end else if (!m_busy && start) begin
         m_res  <= model(int'(mw), int'(mh), seed);
         m_left <= int'(model(int'(mw), int'(mh), seed).cyc);
         m_busy <= 1'b1;
         m_done <= 1'b0;
      end else if (m_busy) begin
         if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_path <= m_res.p;
            m_sx   <= 5'd1;
            m_sy   <= 5'd1;
            m_fx   <= m_res.fx;
            m_fy   <= m_res.fy;
         end else
            m_left <= m_left - 1;
      end
   end

   always @(negedge clk) begin
      chk("cyc_busy", busy, m_busy);
      chk("cyc_done", done, m_done);
      chk("cyc_start_x", start_x, m_sx);
      chk("cyc_start_y", start_y, m_sy);
      chk("cyc_finish_x", finish_x, m_fx);
      chk("cyc_finish_y", finish_y, m_fy);
      if (!m_busy) chk("cyc_path", path_data, m_path);
   end

   task automatic run(input logic [4:0] w, input logic [4:0] h, input logic [15:0] s,
                      input int pulse_at, output int cyc);
      @(negedge clk);
      mw = w;
      mh = h;
      seed = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_rise", busy, 1'b1);
      chk("done_drop", done, 1'b0);
      cyc = 0;
      while (busy && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         start = (cyc == pulse_at);
      end
      start = 1'b0;
      if (cyc >= 2000) begin
         tests++;
         fails++;
         $display("FAIL run_timeout: busy still high after %0d cycles", cyc);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int           cyc;
      logic [255:0] p1, p0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_path", path_data, '0);
      chk("rst_finish_x", finish_x, 5'd0);

      run(5'd3, 5'd3, 16'h0005, -1, cyc);
      chk("min_cycles", cyc, 4);
      chk("min_done", done, 1'b1);
      chk("min_path", path_data, 256'h20000);
      chk("min_start", {start_x, start_y}, {5'd1, 5'd1});
      chk("min_finish", {finish_x, finish_y}, {5'd1, 5'd1});

      run(5'd15, 5'd15, 16'h1234, -1, cyc);
      p1 = path_data;
      chk("full_cycles", cyc, 196);
      chk("full_popcount", $countones(path_data), 97);
      chk("full_tree", tree_errs(path_data, 15, 15), 0);
      chk("full_finish", {finish_x, finish_y}, {5'd13, 5'd13});

      run(5'd15, 5'd15, 16'h1234, -1, cyc);
      chk("repeat_same", path_data, p1);
      run(5'd15, 5'd15, 16'h4321, -1, cyc);
      chk("seed_differs", path_data != p1, 1'b1);
      chk("seed2_tree", tree_errs(path_data, 15, 15), 0);
      run(5'd15, 5'd15, 16'h0000, -1, cyc);
      p0 = path_data;
      run(5'd15, 5'd15, 16'hACE1, -1, cyc);
      chk("seed0_default", path_data, p0);

      run(5'd20, 5'd6, 16'hBEEF, -1, cyc);
      chk("clamp_cycles", cyc, 84);
      chk("clamp_tree", tree_errs(path_data, 15, 7), 0);
      chk("clamp_rows", path_data >> 112, '0);
      chk("clamp_finish", {finish_x, finish_y}, {5'd13, 5'd5});

      run(5'd4, 5'd9, 16'h0F0F, -1, cyc);
      chk("odd_cycles", cyc, 32);
      chk("odd_tree", tree_errs(path_data, 5, 9), 0);

      run(5'd15, 5'd15, 16'h1234, 10, cyc);
      chk("ignored_cycles", cyc, 196);
      chk("ignored_path", path_data, p1);

      @(negedge clk);
      mw = 5'd15;
      mh = 5'd15;
      seed = 16'h1234;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (50) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_path", path_data, '0);
      @(negedge clk);
      #2 reset = 1'b1;
      repeat (5) @(negedge clk);
      chk("midrst_idle", busy, 1'b0);

      run(5'd15, 5'd15, 16'h1234, -1, cyc);
      chk("after_rst_path", path_data, p1);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/maze_carver.md
# maze_carver

Generates the maze bitmap that the VGA maze renderer displays. On a start pulse, it carves a perfect maze with a randomized depth-first search over a grid of at most 16×16 tiles. The result is driven on the same `path_data`, start and finish buses the renderer reads. The block is the writer side of that interface; the top level gates `maze_screen` with `done`.

## Interface
- `CELLS`, 64: stack depth; the maximum number of odd-coordinate cells (8×8).
- `LFSR_INIT`, 16'hACE1: LFSR value used when `seed` is 0.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low (asserted at 0).
- `start` in 1: start generation. Sampled only in IDLE.
- `seed` in 16: LFSR seed, latched on an accepted `start`.
- `maze_width`, `maze_height` in 5: requested size in tiles, latched on an accepted `start`.
- `path_data` out 256: bit `x + 16*y` is 1 when tile (x,y) is carved.
- `start_x`, `start_y`, `finish_x`, `finish_y` out 5: entry and exit tiles.
- `busy` out 1: generation in progress.
- `done` out 1: a maze is complete. Holds high until the next accepted `start`.

## Operation
- **Effective size.** For each dimension d, `e = (d>15) ? 15 : (d<3) ? 3 : (d|1)`. Values are always odd and within 3..15.
- **Cells.** Cells sit at odd (x,y) with 1 ≤ x ≤ ew−2 and 1 ≤ y ≤ eh−2. Even positions are walls.
- **Visited test.** A cell is visited when its `path_data` bit is 1.
- **LFSR.** 16-bit Fibonacci, taps 16,14,13,11. It shifts once per clock while `busy`=1.
- **Stack.** CELLS entries of 6 bits ({y[3:1], x[3:1]}), with a 7-bit `sp`. It cannot overflow.

States:
- **IDLE**
  - On `start`=1: latch sizes and seed, load the LFSR, go to CLEAR.
  - `start`=0: stay in IDLE.
- **CLEAR** (1 cycle)
  - `path_data` ← 0, `done` ← 0.
  - Go to INIT.
- **INIT** (1 cycle)
  - Set bit (1,1), push (1,1), cur ← (1,1), `sp` ← 1.
  - Go to PICK.
- **PICK** (1 cycle)
  - Build `mask`[3:0] over directions N(0), E(1), S(2), W(3). A bit is set when the cell at distance 2 in that direction lies inside the cell range and is unvisited.
  - If `mask` ≠ 0: choose the first set bit scanning upward from `lfsr[1:0]` mod 4. Go to CARVE.
  - If `mask` = 0: go to BACKTRACK.
- **CARVE** (1 cycle)
  - Set the wall bit at cur+dir and the cell bit at cur+2·dir.
  - Push the target cell; cur ← target.
  - Go to PICK.
- **BACKTRACK** (1 cycle)
  - Pop (`sp` ← `sp`−1).
  - If the new `sp` is 0: `start_x/y` ← (1,1), `finish_x/y` ← (ew−2, eh−2), `done` ← 1. Go to IDLE.
  - Otherwise: cur ← new top. Go to PICK.

Outputs:
- `busy` is 1 in every state except IDLE.
- `start_*` and `finish_*` keep their previous values until the completing BACKTRACK.
- `path_data` is live during generation. Consumers use it only while `done`=1.

Boundary conditions:
- `start` while `busy`=1 is ignored.
- `start` in IDLE with `done`=1 regenerates the maze (new CLEAR).
- A `start` held high for multiple cycles starts exactly one run, plus another run per IDLE cycle in which it is still seen high.
- `reset` asserted mid-run: all state returns to reset values immediately, and the run is abandoned.
- `seed`=0 uses `LFSR_INIT`. The LFSR never holds 0.

## Timing
- Reset values: `path_data`=0, all coordinate outputs 0, `busy`=0, `done`=0, state IDLE, `sp`=0, LFSR=`LFSR_INIT`.
- Handshake:
  - `start` sampled at edge k moves the state to CLEAR, so `busy`=1 from k.
  - `done` and the coordinate outputs update at the same edge where `busy` falls.
- Latency: with N = ((ew−1)/2)·((eh−1)/2) cells, `busy` is high for exactly 4N cycles (CLEAR + INIT + 2(N−1) for carving + 2N for backtracking).
- Result invariant: exactly 2N−1 bits of `path_data` are set, forming a spanning tree over the cells. Bits outside [0,ew−1]×[0,eh−1] are 0.

## Test plan
- **Reset.** Assert `reset`=0 mid-generation of a 15×15 maze → next cycle: `busy`=0, `done`=0, `path_data`=0. No activity until the next `start`.
- **Minimum size.** `maze_width`=`maze_height`=3, `start` pulse → `busy` high for 4 cycles. Then `done`=1, `path_data` has only bit 17 set, start=(1,1), finish=(1,1).
- **Full size.** 15×15, seed 16'h1234 → `busy` for 196 cycles. Then `done`=1, 97 bits set, all 49 odd cells set, every even-even tile 0, finish=(13,13). A BFS from (1,1) reaches all cells, and the graph has no cycle.
- **Size clamping.** `maze_width`=20, `maze_height`=6 → effective 15×7, N=21, `busy` for 84 cycles. No bit set in any row y ≥ 7 or column x ≥ 15.
- **Determinism.** Repeat with the same seed → identical `path_data`. A different seed → a different `path_data`. `seed`=0 matches seed 16'hACE1.
- **Ignored start.** Pulse `start` at cycle 10 of a run → cycle count and result are unchanged. A `start` after `done` → `done` drops at the next edge and the maze regenerates.
